// File: rtl/mmult_opt_mdc_package.sv
// Shared types and constants for the mmult_opt MDC engine and its kernel adapter.
package mmult_opt_mdc_package;

    localparam int unsigned MMULT_OPT_MDC_CNT_LEN = 1024;
    localparam int unsigned MMULT_OPT_MDC_CW      = $clog2(MMULT_OPT_MDC_CNT_LEN) + 1;

    // Control from the engine control FSM.
    typedef struct packed {
        logic                        clear;
        logic                        enable;
        logic                        start;
        logic [MMULT_OPT_MDC_CW-1:0] cnt_limit_out_r;
    } ctrl_engine_t;

    // Status back to the engine control FSM.
    typedef struct packed {
        logic [MMULT_OPT_MDC_CW-1:0] cnt_out_r;
        logic                        done;
        logic                        ready;
    } flags_engine_t;

    // ap_start-style kick to the HLS kernel.
    typedef struct packed {
        logic start;
    } ctrl_kernel_adapter_t;

    // ap_done / ap_idle / ap_ready from the HLS kernel.
    typedef struct packed {
        logic done;
        logic idle;
        logic ready;
    } flags_kernel_adapter_t;

    // Kernel adapter job FSM.
    typedef enum logic [1:0] {
        ADP_IDLE  = 2'd0,
        ADP_START = 2'd1,
        ADP_RUN   = 2'd2,
        ADP_DONE  = 2'd3
    } adapter_state_t;

endpackage

// File: rtl/mmult_opt_mdc_beat_counter.sv
// Saturating output-stream beat counter; never wraps past the programmed limit.
module mmult_opt_mdc_beat_counter
    import mmult_opt_mdc_package::*;
#(
    parameter int unsigned CW = MMULT_OPT_MDC_CW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear,
    input  logic          enable,
    input  logic          inc,
    input  logic [CW-1:0] limit,
    output logic [CW-1:0] count
);

    // Count accepted beats, holding once the limit is reached.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && inc && (count < limit)) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mmult_opt_mdc_kernel_adapter.sv
// Bridges the engine control FSM to an ap_ctrl_hs HLS kernel and counts its out_r beats.
module mmult_opt_mdc_kernel_adapter
    import mmult_opt_mdc_package::*;
#(
    parameter int unsigned CNT_LEN = MMULT_OPT_MDC_CNT_LEN
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  ctrl_engine_t          ctrl_i,
    output flags_engine_t         flags_o,
    output ctrl_kernel_adapter_t  kernel_ctrl_o,
    input  flags_kernel_adapter_t kernel_flags_i,
    input  logic                  out_r_valid_i,
    input  logic                  out_r_ready_i
);

    localparam int unsigned CW = $clog2(CNT_LEN) + 1;
    localparam int unsigned PW = MMULT_OPT_MDC_CW;

    adapter_state_t state_q, state_d;
    logic [CW-1:0]  limit_q;
    logic [CW-1:0]  count;
    logic           done_seen_q;
    logic           start_q, start_d;
    logic           done_q, done_d;
    logic           ready_q, ready_d;

    logic job_accept;
    logic beat;
    logic at_limit;
    logic reach_limit;
    logic kernel_done_any;
    logic unused_idle;

    // idle is informational only; the handshake is driven by ready/done.
    assign unused_idle = kernel_flags_i.idle;

    assign job_accept      = (state_q == ADP_IDLE) && ctrl_i.start && ctrl_i.enable && !ctrl_i.clear;
    assign beat            = out_r_valid_i && out_r_ready_i && ctrl_i.enable;
    assign at_limit        = (count == limit_q);
    assign reach_limit     = beat && ((count + CW'(1)) == limit_q);
    assign kernel_done_any = done_seen_q || kernel_flags_i.done;

    // Next-state and next-output decode; clear overrides everything.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        ready_d = 1'b0;
        if (ctrl_i.clear) begin
            state_d = ADP_IDLE;
        end else begin
            case (state_q)
                ADP_IDLE: begin
                    if (job_accept) state_d = ADP_START;
                end
                ADP_START: begin
                    if (ctrl_i.enable && kernel_flags_i.ready) state_d = ADP_RUN;
                end
                ADP_RUN: begin
                    if (ctrl_i.enable && kernel_done_any && (at_limit || reach_limit)) begin
                        state_d = ADP_DONE;
                    end
                end
                ADP_DONE: begin
                    // Always leave so the done pulse is exactly one cycle wide.
                    state_d = ADP_IDLE;
                end
                default: state_d = ADP_IDLE;
            endcase
        end
        start_d = (state_d == ADP_START);
        done_d  = (state_d == ADP_DONE);
        ready_d = (state_d == ADP_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ADP_IDLE;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    // Latch the beat limit when a job is accepted; later changes are ignored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            limit_q <= '0;
        end else if (job_accept) begin
            limit_q <= CW'(ctrl_i.cnt_limit_out_r);
        end
    end

    // Sticky record that the kernel finished, since ap_done may precede the last beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_seen_q <= 1'b0;
        end else if (ctrl_i.clear || job_accept) begin
            done_seen_q <= 1'b0;
        end else if (((state_q == ADP_START) || (state_q == ADP_RUN)) && kernel_flags_i.done) begin
            done_seen_q <= 1'b1;
        end
    end

    mmult_opt_mdc_beat_counter #(
        .CW (CW)
    ) u_beat_counter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (ctrl_i.clear || job_accept),
        .enable (ctrl_i.enable),
        .inc    ((state_q == ADP_RUN) && out_r_valid_i && out_r_ready_i),
        .limit  (limit_q),
        .count  (count)
    );

    assign flags_o.cnt_out_r   = PW'(count);
    assign flags_o.done        = done_q;
    assign flags_o.ready       = ready_q;
    assign kernel_ctrl_o.start = start_q;

endmodule

// File: tb/tb_mmult_opt_mdc_kernel_adapter.sv
// Directed scoreboard bench for the mmult_opt MDC kernel adapter.
module tb_mmult_opt_mdc_kernel_adapter;
    import mmult_opt_mdc_package::*;

    localparam int unsigned PW = MMULT_OPT_MDC_CW;

    logic                  clk = 1'b0;
    logic                  rst;
    ctrl_engine_t          ctrl;
    flags_engine_t         flags;
    ctrl_kernel_adapter_t  kctrl;
    flags_kernel_adapter_t kflags;
    logic                  valid;
    logic                  rdy;

    int checks = 0;
    int fails  = 0;
    int dones  = 0;
    int pushed = 0;
    int exp_q[$];
    int mon_exp;

    always #5 clk = ~clk;

    mmult_opt_mdc_kernel_adapter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ctrl_i         (ctrl),
        .flags_o        (flags),
        .kernel_ctrl_o  (kctrl),
        .kernel_flags_i (kflags),
        .out_r_valid_i  (valid),
        .out_r_ready_i  (rdy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_done(input int cnt);
        exp_q.push_back(cnt);
        pushed++;
    endtask

    // Issue a job, hold kernel ap_ready off for nhigh-1 sampled cycles, then acknowledge.
    task automatic launch(input int limit, input int nhigh);
        ctrl.start           = 1'b1;
        ctrl.cnt_limit_out_r = PW'(limit);
        tick();
        ctrl.start           = 1'b0;
        ctrl.cnt_limit_out_r = PW'(limit + 3);
        check("launch_ready_low", int'(flags.ready), 0);
        check("launch_cnt_zero", int'(flags.cnt_out_r), 0);
        for (int i = 0; i < nhigh; i++) begin
            check($sformatf("start_high_%0d", i), int'(kctrl.start), 1);
            if (i == nhigh - 1) kflags.ready = 1'b1;
            tick();
        end
        kflags.ready = 1'b0;
        check("start_drop", int'(kctrl.start), 0);
    endtask

    task automatic beats(input int n);
        valid = 1'b1;
        rdy   = 1'b1;
        repeat (n) tick();
        valid = 1'b0;
        rdy   = 1'b0;
    endtask

    task automatic pulse_kdone();
        kflags.done = 1'b1;
        tick();
        kflags.done = 1'b0;
    endtask

    // Scoreboard monitor: every done pulse must match the next expected final count.
    always @(negedge clk) begin
        if (!rst && flags.done) begin
            dones++;
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done actual_cnt=%0d required=no done pulse", flags.cnt_out_r);
            end else begin
                mon_exp = exp_q.pop_front();
                if (int'(flags.cnt_out_r) !== mon_exp) begin
                    fails++;
                    $display("FAIL done_cnt actual=%0d required=%0d", flags.cnt_out_r, mon_exp);
                end
            end
            checks++;
            if (flags.ready !== 1'b0) begin
                fails++;
                $display("FAIL done_ready_excl actual=%0d required=0", flags.ready);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        ctrl   = '0;
        kflags = '0;
        valid  = 1'b0;
        rdy    = 1'b0;
        repeat (2) tick();
        check("rst_start", int'(kctrl.start), 0);
        check("rst_done", int'(flags.done), 0);
        check("rst_cnt", int'(flags.cnt_out_r), 0);
        rst         = 1'b0;
        ctrl.enable = 1'b1;
        tick();
        check("rst_ready", int'(flags.ready), 1);

        // Limit 16, ready after 3 start cycles, 16 beats, done after the last beat.
        expect_done(16);
        launch(16, 3);
        beats(16);
        check("t1_cnt", int'(flags.cnt_out_r), 16);
        check("t1_no_done_yet", int'(flags.done), 0);
        pulse_kdone();
        check("t1_done", int'(flags.done), 1);
        tick();
        check("t1_done_clear", int'(flags.done), 0);
        check("t1_ready", int'(flags.ready), 1);
        check("t1_cnt_hold", int'(flags.cnt_out_r), 16);

        // Limit 8, kernel done before the 8th beat.
        expect_done(8);
        launch(8, 2);
        beats(5);
        check("t2_cnt5", int'(flags.cnt_out_r), 5);
        pulse_kdone();
        check("t2_no_early_done_a", int'(flags.done), 0);
        beats(2);
        check("t2_cnt7", int'(flags.cnt_out_r), 7);
        check("t2_no_early_done_b", int'(flags.done), 0);
        beats(1);
        check("t2_done_after_8th", int'(flags.done), 1);
        tick();
        check("t2_done_clear", int'(flags.done), 0);

        // Limit 4, 6 beats: saturate.
        expect_done(4);
        launch(4, 1);
        beats(6);
        check("t3_sat", int'(flags.cnt_out_r), 4);
        check("t3_no_done", int'(flags.done), 0);
        pulse_kdone();
        check("t3_done", int'(flags.done), 1);
        tick();
        check("t3_single_pulse", int'(flags.done), 0);
        check("t3_ready", int'(flags.ready), 1);

        // Limit 10, enable low for 5 cycles mid-run with beats offered.
        expect_done(10);
        launch(10, 1);
        beats(3);
        check("t4_cnt3", int'(flags.cnt_out_r), 3);
        ctrl.enable = 1'b0;
        valid       = 1'b1;
        rdy         = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t4_frozen_%0d", i), int'(flags.cnt_out_r), 3);
        end
        ctrl.enable = 1'b1;
        beats(7);
        check("t4_cnt10", int'(flags.cnt_out_r), 10);
        pulse_kdone();
        check("t4_done", int'(flags.done), 1);
        tick();

        // Clear at count 3 of 10, then clear+start together, then a clean job.
        launch(10, 1);
        beats(3);
        check("t5_cnt3", int'(flags.cnt_out_r), 3);
        ctrl.clear = 1'b1;
        tick();
        ctrl.clear = 1'b0;
        check("t5_clr_ready", int'(flags.ready), 1);
        check("t5_clr_cnt", int'(flags.cnt_out_r), 0);
        check("t5_clr_done", int'(flags.done), 0);
        check("t5_clr_start", int'(kctrl.start), 0);
        ctrl.clear           = 1'b1;
        ctrl.start           = 1'b1;
        ctrl.cnt_limit_out_r = PW'(5);
        tick();
        ctrl.clear = 1'b0;
        ctrl.start = 1'b0;
        check("t5_clr_wins_start", int'(kctrl.start), 0);
        check("t5_clr_wins_ready", int'(flags.ready), 1);
        tick();
        check("t5_no_job", int'(kctrl.start), 0);
        expect_done(2);
        launch(2, 1);
        beats(2);
        check("t5_cnt2", int'(flags.cnt_out_r), 2);
        check("t5_no_done", int'(flags.done), 0);
        pulse_kdone();
        check("t5_done", int'(flags.done), 1);
        tick();

        // Async reset in the middle of ADP_START, then a limit-0 job.
        ctrl.start           = 1'b1;
        ctrl.cnt_limit_out_r = PW'(7);
        tick();
        ctrl.start = 1'b0;
        check("t6_start_high", int'(kctrl.start), 1);
        #2 rst = 1'b1;
        #1 check("t6_async_start_drop", int'(kctrl.start), 0);
        #4 rst = 1'b0;
        tick();
        check("t6_ready_after_rst", int'(flags.ready), 1);
        check("t6_cnt_after_rst", int'(flags.cnt_out_r), 0);
        check("t6_done_after_rst", int'(flags.done), 0);
        tick();
        check("t6_no_restart", int'(kctrl.start), 0);
        expect_done(0);
        launch(0, 1);
        repeat (2) tick();
        check("t6_no_done_wo_kernel", int'(flags.done), 0);
        pulse_kdone();
        check("t6_done", int'(flags.done), 1);
        check("t6_cnt0", int'(flags.cnt_out_r), 0);
        tick();

        // Drain: every expected done must have been seen, within a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        check("queue_drain", exp_q.size(), 0);
        check("done_count", dones, pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
